// File: rtl/if_id_stage_if.sv
// IF/ID stage bus: fetch-side handshake, hazard controls, decode-side
// outputs and the two performance counters, bundled for the pipeline stage.
interface if_id_stage_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) ();
    logic               in_valid;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic               stall;
    logic               flush;
    logic               out_valid;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [31:0]        stall_cycles;
    logic [31:0]        flush_count;

    // Pipeline side: drives fetch data and hazard controls, observes ID.
    modport master (
        output in_valid, in_pc, in_instr, stall, flush,
        input  in_ready, out_valid, out_pc, out_instr, stall_cycles, flush_count
    );

    // Stage side.
    modport slave (
        input  in_valid, in_pc, in_instr, stall, flush,
        output in_ready, out_valid, out_pc, out_instr, stall_cycles, flush_count
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: valid-tagged output register fed either directly
// from IF (bypass) or from an in-order SKID_DEPTH-entry skid queue that
// captures fetches arriving while ID is stalled. All state changes on the
// falling edge of clk; rst is synchronous and active-high.
// Optional macro IF_ID_PERF_CNT_EN builds saturating stall/flush counters;
// without it both counter outputs read zero and no counter flops exist.
module if_id_stage #(
    parameter int                 PC_W       = 32,
    parameter int                 INSTR_W    = 32,
    parameter logic [INSTR_W-1:0] BUBBLE     = 32'hFFFFFFFF,
    parameter int                 SKID_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    if_id_stage_if.slave  bus
);
    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKID_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SKID_DEPTH);

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            ptr_next = {PTR_W{1'b0}};
        end else begin
            ptr_next = p + {{(PTR_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic               out_valid_q, out_valid_d;
    logic [PC_W-1:0]    out_pc_q,    out_pc_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [PC_W-1:0]    skid_pc_q    [SKID_DEPTH];
    logic [INSTR_W-1:0] skid_instr_q [SKID_DEPTH];

    logic in_ready_s;
    logic accept_s;
    logic push_s;

    // Readiness looks only at reset and the registered occupancy.
    always_comb begin
        in_ready_s = !rst && (count_q < CNT_FULL);
        accept_s   = bus.in_valid && in_ready_s;
    end

    // Next-state selection: flush beats stall beats advance.
    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        push_s      = 1'b0;

        if (bus.flush) begin
            // Squash output and queue; any same-edge input is dropped.
            out_valid_d = 1'b0;
            out_instr_d = BUBBLE;
            count_d     = {CNT_W{1'b0}};
            wr_ptr_d    = {PTR_W{1'b0}};
            rd_ptr_d    = {PTR_W{1'b0}};
        end else if (bus.stall) begin
            // ID holds; capture the fetch at the tail.
            if (accept_s) begin
                push_s   = 1'b1;
                wr_ptr_d = ptr_next(wr_ptr_q);
                count_d  = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                push_s   = 1'b0;
            end
        end else begin
            if (count_q != {CNT_W{1'b0}}) begin
                // Drain the oldest queued instruction first.
                out_valid_d = 1'b1;
                out_pc_d    = skid_pc_q[rd_ptr_q];
                out_instr_d = skid_instr_q[rd_ptr_q];
                rd_ptr_d    = ptr_next(rd_ptr_q);
                if (accept_s) begin
                    push_s   = 1'b1;
                    wr_ptr_d = ptr_next(wr_ptr_q);
                end else begin
                    count_d  = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else if (accept_s) begin
                // Empty queue: fetch goes straight to ID.
                out_valid_d = 1'b1;
                out_pc_d    = bus.in_pc;
                out_instr_d = bus.in_instr;
            end else begin
                out_valid_d = 1'b0;
                out_instr_d = BUBBLE;
            end
        end
    end

    // Output register, occupancy and pointers.
    always_ff @(negedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= {PC_W{1'b0}};
            out_instr_q <= BUBBLE;
            count_q     <= {CNT_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Skid storage; contents are meaningless outside the occupied window.
    always_ff @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_pc_q[i]    <= {PC_W{1'b0}};
                skid_instr_q[i] <= BUBBLE;
            end
        end else if (push_s) begin
            skid_pc_q[wr_ptr_q]    <= bus.in_pc;
            skid_instr_q[wr_ptr_q] <= bus.in_instr;
        end else begin
            skid_pc_q[wr_ptr_q]    <= skid_pc_q[wr_ptr_q];
            skid_instr_q[wr_ptr_q] <= skid_instr_q[wr_ptr_q];
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.out_instr = out_instr_q;

`ifdef IF_ID_PERF_CNT_EN
    // Saturating increment so a long run never wraps back to small values.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFFFFFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 32'd1;
        end
    endfunction

    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    // Stall edges count only when not overridden by flush.
    always_ff @(negedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            if (bus.flush) begin
                flush_count_q <= sat_inc(flush_count_q);
            end else begin
                flush_count_q <= flush_count_q;
            end
            if (bus.stall && !bus.flush) begin
                stall_cycles_q <= sat_inc(stall_cycles_q);
            end else begin
                stall_cycles_q <= stall_cycles_q;
            end
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`else
    assign bus.stall_cycles = 32'd0;
    assign bus.flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_if_id_stage;
    localparam int DEPTH = 2;
    localparam logic [31:0] BUB = 32'hFFFFFFFF;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    if_id_stage_if #(.PC_W(32), .INSTR_W(32)) ifc ();

    if_id_stage #(
        .PC_W(32), .INSTR_W(32), .BUBBLE(32'hFFFFFFFF), .SKID_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: FIFO of {pc,instr} plus the visible output state.
    logic [63:0] m_q[$];
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_sc;
    logic [31:0] m_fc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One falling-edge step: inputs applied mid-cycle, ready checked before
    // the edge, outputs checked just after it.
    task automatic step(input logic r, input logic v, input logic s, input logic f,
                        input logic [31:0] pc, input logic [31:0] instr);
        logic ready;
        logic acc;
        logic [63:0] head;
        rst           = r;
        ifc.in_valid  = v;
        ifc.in_pc     = pc;
        ifc.in_instr  = instr;
        ifc.stall     = s;
        ifc.flush     = f;
        @(posedge clk);
        ready = !r && (m_q.size() < DEPTH);
        check("in_ready", {63'd0, ifc.in_ready}, {63'd0, ready});
        acc = v && ready;
        @(negedge clk);
        if (r) begin
            m_q.delete();
            m_valid = 1'b0; m_pc = 32'd0; m_instr = BUB;
            m_sc = 32'd0; m_fc = 32'd0;
        end else if (f) begin
            m_q.delete();
            m_valid = 1'b0; m_instr = BUB;
            if (m_fc != 32'hFFFFFFFF) m_fc = m_fc + 32'd1;
        end else if (s) begin
            if (acc) m_q.push_back({pc, instr});
            if (m_sc != 32'hFFFFFFFF) m_sc = m_sc + 32'd1;
        end else begin
            if (acc) m_q.push_back({pc, instr});
            if (m_q.size() > 0) begin
                head = m_q.pop_front();
                m_valid = 1'b1; m_pc = head[63:32]; m_instr = head[31:0];
            end else begin
                m_valid = 1'b0; m_instr = BUB;
            end
        end
        #1;
        check("out_valid", {63'd0, ifc.out_valid}, {63'd0, m_valid});
        check("out_pc",    {32'd0, ifc.out_pc},    {32'd0, m_pc});
        check("out_instr", {32'd0, ifc.out_instr}, {32'd0, m_instr});
`ifdef IF_ID_PERF_CNT_EN
        check("stall_cycles", {32'd0, ifc.stall_cycles}, {32'd0, m_sc});
        check("flush_count",  {32'd0, ifc.flush_count},  {32'd0, m_fc});
`else
        check("stall_cycles_off", {32'd0, ifc.stall_cycles}, 64'd0);
        check("flush_count_off",  {32'd0, ifc.flush_count},  64'd0);
`endif
    endtask

    initial begin
        n_checks = 0; n_err = 0;
        m_valid = 1'b0; m_pc = 32'd0; m_instr = BUB; m_sc = 32'd0; m_fc = 32'd0;
        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_pc = 32'd0; ifc.in_instr = 32'd0;
        ifc.stall = 1'b0; ifc.flush = 1'b0;

        // Reset held two edges while IF offers an instruction.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 32'h20080001);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 32'h20080001);

        // Bypass path: one edge of latency, no queuing.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 32'h20080001);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h04, 32'h20080002);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h08, 32'h20080003);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0);

        // Skid fill: out holds 0x04, stall while 0x08/0x0C/0x10 offered.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 32'h20080001);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h04, 32'h20080002);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h08, 32'h20080003);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0C, 32'h20080004);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h20080005);
        // Release: IF keeps offering 0x10 until it is taken.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20080005);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20080005);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0);

        // Flush with a full queue and a live input.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 32'h20080001);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h04, 32'h20080002);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h08, 32'h20080003);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0C, 32'h20080004);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h20080005);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0);

        // Stall and flush together, then reset with one entry queued.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h11111111);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h24, 32'h22222222);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h28, 32'h33333333);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h2C, 32'h44444444);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0);

        // Counters: 5 stalls, 2 flushes, 1 stall+flush from a clean reset.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
`ifdef IF_ID_PERF_CNT_EN
        check("stall_cycles_5", {32'd0, ifc.stall_cycles}, 64'd5);
        check("flush_count_3",  {32'd0, ifc.flush_count},  64'd3);
        force dut.stall_cycles_q = 32'hFFFFFFFF;
        #1;
        release dut.stall_cycles_q;
        m_sc = 32'hFFFFFFFF;
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        check("stall_cycles_sat", {32'd0, ifc.stall_cycles}, {32'd0, 32'hFFFFFFFF});
`else
        check("stall_cycles_zero", {32'd0, ifc.stall_cycles}, 64'd0);
        check("flush_count_zero",  {32'd0, ifc.flush_count},  64'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) == 0),
                 $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
